// File: rtl/product_accumulator_pkg.sv
// rtl/product_accumulator_pkg.sv - shared types and constants for product_accumulator
//
// Purpose: this package holds the FSM state encoding, the width of the incoming
// product and the counter, and helpers that derive the signed saturation limits
// from an accumulator width.
// Ports: none (package).
// Build option: ACC_SAT_EN (the saturation limits are only consumed when it is defined).
package product_accumulator_pkg;

  localparam int PROD_W = 8;  // product width from the 4x4 Booth stage
  localparam int CNT_W  = 8;  // holds FRAME_LEN-1 for FRAME_LEN up to 255

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // Most positive signed value of an acc_w-bit word, as a 32-bit pattern.
  function automatic logic [31:0] sat_max_f(input int unsigned acc_w);
    return (32'd1 << (acc_w - 1)) - 32'd1;
  endfunction

  // Most negative signed value of an acc_w-bit word, as a 32-bit pattern
  // (the caller truncates it to acc_w bits).
  function automatic logic [31:0] sat_min_f(input int unsigned acc_w);
    return 32'd1 << (acc_w - 1);
  endfunction

endpackage

// File: rtl/sat_adder.sv
// rtl/sat_adder.sv - ACC_W-bit signed adder with overflow flag and optional clamp
//
// Purpose: this module adds two signed words and flags a signed overflow. When
// the macro ACC_SAT_EN is defined, an overflowing result is clamped to the
// signed limit. Otherwise the result wraps modulo 2^ACC_W.
// Ports:
//   i_a, i_b : signed addends (ACC_W bits)
//   o_sum    : signed result, clamped or wrapped (ACC_W bits)
//   o_ovf    : true result lies outside the ACC_W-bit signed range
// Build option: ACC_SAT_EN.
module sat_adder
  import product_accumulator_pkg::*;
#(
  parameter int ACC_W = 12
) (
  input  logic signed [ACC_W-1:0] i_a,
  input  logic signed [ACC_W-1:0] i_b,
  output logic signed [ACC_W-1:0] o_sum,
  output logic                    o_ovf
);

  logic [ACC_W-1:0] w_raw;

  assign w_raw = i_a + i_b;

  // Overflow is only possible when both addends share a sign. It has occurred
  // when the wrapped result does not share that sign.
  assign o_ovf = (i_a[ACC_W-1] == i_b[ACC_W-1]) && (w_raw[ACC_W-1] != i_a[ACC_W-1]);

`ifdef ACC_SAT_EN
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max_f(ACC_W));
  localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min_f(ACC_W));

  // The sign of the operands gives the direction of the overflow.
  assign o_sum = o_ovf ? (i_a[ACC_W-1] ? SAT_MIN : SAT_MAX) : w_raw;
`else
  assign o_sum = w_raw;
`endif

endmodule

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - frames of FRAME_LEN signed products summed into ACC_W bits
//
// Purpose: this module accepts signed 8-bit products with a valid/ready handshake
// and sums FRAME_LEN of them. It presents each frame sum, together with a sticky
// overflow flag, through a second valid/ready handshake.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : product handshake, in_prod (8-bit signed)
//   clear               : synchronous frame abort that also discards a held frame
//   out_valid/out_ready : frame handshake, out_sum (ACC_W signed), out_ovf
// Build option: ACC_SAT_EN (saturating accumulate, handled in sat_adder).
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int ACC_W     = 12,
  parameter int FRAME_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] in_prod,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_sum,
  output logic                     out_ovf
);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_ovf;
  logic signed [ACC_W-1:0] r_sum;
  logic                    r_out_ovf;

  logic signed [ACC_W-1:0] w_ext;
  logic signed [ACC_W-1:0] w_add_sum;
  logic                    w_add_ovf;
  logic                    w_accept;
  logic                    w_deliver;
  logic                    w_last;

  // A size cast of a signed operand sign-extends it, and this also works when ACC_W == PROD_W.
  assign w_ext     = ACC_W'(in_prod);
  assign w_accept  = in_valid && in_ready;
  assign w_deliver = out_valid && out_ready;
  assign w_last    = (r_cnt == CNT_W'(FRAME_LEN - 1));

  sat_adder #(
    .ACC_W (ACC_W)
  ) u_sat_adder (
    .i_a   (r_acc),
    .i_b   (w_ext),
    .o_sum (w_add_sum),
    .o_ovf (w_add_ovf)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. A clear overrides any accept or delivery in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ST_ACCUM;
    end else begin
      case (r_state)
        ST_ACCUM: if (w_accept && w_last) w_state_nxt = ST_HOLD;
        ST_HOLD:  if (w_deliver)          w_state_nxt = ST_ACCUM;
        default:                          w_state_nxt = ST_ACCUM;
      endcase
    end
  end

  // Outputs decoded from the state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_ACCUM: in_ready  = 1'b1;
      ST_HOLD:  out_valid = 1'b1;
      default:  in_ready  = 1'b0;
    endcase
  end

  // Accumulator, counter and result registers. The running acc, cnt and ovf are
  // zeroed on the last accept, while the finished frame moves into r_sum and
  // r_out_ovf. No product can be accepted in HOLD, so these registers are
  // already in their post-delivery state when the FSM returns to ACCUM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_sum     <= '0;
      r_out_ovf <= 1'b0;
    end else if (clear) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      if (w_last) begin
        r_sum     <= w_add_sum;
        r_out_ovf <= r_ovf || w_add_ovf;
        r_acc     <= '0;
        r_cnt     <= '0;
        r_ovf     <= 1'b0;
      end else begin
        r_acc <= w_add_sum;
        r_cnt <= r_cnt + CNT_W'(1);
        r_ovf <= r_ovf || w_add_ovf;
      end
    end
  end

  assign out_sum = r_sum;
  assign out_ovf = r_out_ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - self-checking bench for product_accumulator
module tb_product_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              in_valid [3];
  logic signed [7:0] in_prod  [3];
  logic              clear    [3];
  logic              out_ready[3];
  logic              in_ready [3];
  logic              out_valid[3];
  logic              out_ovf  [3];
  logic signed [11:0] sum_a;
  logic signed [7:0]  sum_b;
  logic signed [7:0]  sum_c;
  logic signed [31:0] sum_ext [3];

  assign sum_ext[0] = 32'(sum_a);
  assign sum_ext[1] = 32'(sum_b);
  assign sum_ext[2] = 32'(sum_c);

  int vectors    = 0;
  int miscompares = 0;

  // d=0: defaults (12-bit, 4 per frame); d=1: 8-bit, 2 per frame; d=2: 8-bit, 4 per frame
  product_accumulator u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_prod(in_prod[0]), .clear(clear[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_sum(sum_a), .out_ovf(out_ovf[0]));

  product_accumulator #(.ACC_W(8), .FRAME_LEN(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_prod(in_prod[1]), .clear(clear[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_sum(sum_b), .out_ovf(out_ovf[1]));

  product_accumulator #(.ACC_W(8), .FRAME_LEN(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_prod(in_prod[2]), .clear(clear[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_sum(sum_c), .out_ovf(out_ovf[2]));

  function automatic int acc_w_of(input int d);
    return (d == 0) ? 12 : 8;
  endfunction

  function automatic int frame_len_of(input int d);
    return (d == 1) ? 2 : 4;
  endfunction

  // Reference: the running sum is kept exactly and folded back into range after
  // every add, either by clamping or by wrapping modulo 2^w.
  function automatic void model(input int d, input int prods[$], output int sum, output bit ovf);
    longint acc, hi, lo, span;
    hi   = (longint'(1) << (acc_w_of(d) - 1)) - 1;
    lo   = -(hi + 1);
    span = 2 * (hi + 1);
    acc  = 0;
    ovf  = 1'b0;
    foreach (prods[i]) begin
      acc = acc + prods[i];
      if (acc > hi) begin
        ovf = 1'b1;
`ifdef ACC_SAT_EN
        acc = hi;
`else
        acc = acc - span;
`endif
      end else if (acc < lo) begin
        ovf = 1'b1;
`ifdef ACC_SAT_EN
        acc = lo;
`else
        acc = acc + span;
`endif
      end
    end
    sum = int'(acc);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offers one product and waits, within a bounded number of cycles, until it is accepted.
  task automatic push(input int d, input int p, output bit ok);
    in_valid[d] = 1'b1;
    in_prod[d]  = 8'(p);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (in_ready[d] === 1'b1) begin
        tick;
        ok = 1'b1;
        break;
      end
      tick;
    end
    in_valid[d] = 1'b0;
  endtask

  function automatic int rnd_prod();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick;
    rst_n = 1'b1;
    tick;
    for (int d = 0; d < 3; d++) begin
      vectors++; if (in_ready[d] !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready d=%0d got=%b exp=1", d, in_ready[d]); end
      vectors++; if (out_valid[d] !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid d=%0d got=%b exp=0", d, out_valid[d]); end
      vectors++; if (sum_ext[d] !== 0) begin miscompares++; $display("FAIL reset_out_sum d=%0d got=%0d exp=0", d, sum_ext[d]); end
      vectors++; if (out_ovf[d] !== 1'b0) begin miscompares++; $display("FAIL reset_out_ovf d=%0d got=%b exp=0", d, out_ovf[d]); end
    end
  endtask

  task automatic test_basic;
    int p [4] = '{-21, -49, 49, 6};
    bit ok;
    out_ready[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(0, p[i], ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL basic_accept i=%0d got=timeout exp=accept", i); end
    end
    // Keep offering during HOLD; the product must not be taken.
    in_valid[0] = 1'b1;
    in_prod[0]  = 8'sd100;
    vectors++; if (out_valid[0] !== 1'b1) begin miscompares++; $display("FAIL basic_valid got=%b exp=1", out_valid[0]); end
    vectors++; if (sum_ext[0] !== -15) begin miscompares++; $display("FAIL basic_sum got=%0d exp=-15", sum_ext[0]); end
    vectors++; if (out_ovf[0] !== 1'b0) begin miscompares++; $display("FAIL basic_ovf got=%b exp=0", out_ovf[0]); end
    vectors++; if (in_ready[0] !== 1'b0) begin miscompares++; $display("FAIL basic_hold_ready got=%b exp=0", in_ready[0]); end
    tick;
    in_valid[0] = 1'b0;
    vectors++; if (out_valid[0] !== 1'b0) begin miscompares++; $display("FAIL basic_pulse got=%b exp=0", out_valid[0]); end
    vectors++; if (in_ready[0] !== 1'b1) begin miscompares++; $display("FAIL basic_back_ready got=%b exp=1", in_ready[0]); end
  endtask

  task automatic test_backpressure;
    int q[$];
    int exp, x, p;
    bit eo, ok;
    out_ready[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      p = rnd_prod();
      q.push_back(p);
      push(0, p, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL bp_accept i=%0d got=timeout exp=accept", i); end
    end
    model(0, q, exp, eo);
    x = rnd_prod();
    in_valid[0] = 1'b1;
    in_prod[0]  = 8'(x);
    for (int c = 0; c < 5; c++) begin
      vectors++; if (in_ready[0] !== 1'b0) begin miscompares++; $display("FAIL bp_ready c=%0d got=%b exp=0", c, in_ready[0]); end
      vectors++; if (out_valid[0] !== 1'b1) begin miscompares++; $display("FAIL bp_valid c=%0d got=%b exp=1", c, out_valid[0]); end
      vectors++; if (sum_ext[0] !== exp) begin miscompares++; $display("FAIL bp_sum c=%0d got=%0d exp=%0d", c, sum_ext[0], exp); end
      tick;
    end
    out_ready[0] = 1'b1;
    vectors++; if (sum_ext[0] !== exp) begin miscompares++; $display("FAIL bp_deliver_sum got=%0d exp=%0d", sum_ext[0], exp); end
    vectors++; if (out_ovf[0] !== eo) begin miscompares++; $display("FAIL bp_deliver_ovf got=%b exp=%b", out_ovf[0], eo); end
    tick;
    vectors++; if (out_valid[0] !== 1'b0) begin miscompares++; $display("FAIL bp_after_valid got=%b exp=0", out_valid[0]); end
    vectors++; if (in_ready[0] !== 1'b1) begin miscompares++; $display("FAIL bp_after_ready got=%b exp=1", in_ready[0]); end
    tick;
    in_valid[0] = 1'b0;
    q.delete();
    q.push_back(x);
    for (int i = 0; i < 3; i++) begin
      p = rnd_prod();
      q.push_back(p);
      push(0, p, ok);
    end
    model(0, q, exp, eo);
    vectors++; if (out_valid[0] !== 1'b1) begin miscompares++; $display("FAIL bp_next_valid got=%b exp=1", out_valid[0]); end
    vectors++; if (sum_ext[0] !== exp) begin miscompares++; $display("FAIL bp_next_sum got=%0d exp=%0d", sum_ext[0], exp); end
    tick;
  endtask

  task automatic test_ovf_small;
    bit ok;
    int exp_pos;
`ifdef ACC_SAT_EN
    exp_pos = 127;
`else
    exp_pos = -128;
`endif
    out_ready[1] = 1'b1;
    push(1, 64, ok);
    push(1, 64, ok);
    vectors++; if (out_valid[1] !== 1'b1) begin miscompares++; $display("FAIL ovf_pos_valid got=%b exp=1", out_valid[1]); end
    vectors++; if (sum_ext[1] !== exp_pos) begin miscompares++; $display("FAIL ovf_pos_sum got=%0d exp=%0d", sum_ext[1], exp_pos); end
    vectors++; if (out_ovf[1] !== 1'b1) begin miscompares++; $display("FAIL ovf_pos_flag got=%b exp=1", out_ovf[1]); end
    tick;
    push(1, -64, ok);
    push(1, -64, ok);
    vectors++; if (sum_ext[1] !== -128) begin miscompares++; $display("FAIL ovf_neg_sum got=%0d exp=-128", sum_ext[1]); end
    vectors++; if (out_ovf[1] !== 1'b0) begin miscompares++; $display("FAIL ovf_neg_flag got=%b exp=0", out_ovf[1]); end
    tick;
    out_ready[1] = 1'b0;
  endtask

  task automatic test_clear;
    int p [4] = '{-40, -10, 6, 15};
    bit ok;
    out_ready[0] = 1'b1;
    push(0, 10, ok);
    push(0, 20, ok);
    clear[0]    = 1'b1;
    in_valid[0] = 1'b1;
    in_prod[0]  = 8'sd77;
    tick;
    clear[0]    = 1'b0;
    in_valid[0] = 1'b0;
    vectors++; if (in_ready[0] !== 1'b1) begin miscompares++; $display("FAIL clr_ready got=%b exp=1", in_ready[0]); end
    for (int i = 0; i < 4; i++) push(0, p[i], ok);
    vectors++; if (out_valid[0] !== 1'b1) begin miscompares++; $display("FAIL clr_valid got=%b exp=1", out_valid[0]); end
    vectors++; if (sum_ext[0] !== -29) begin miscompares++; $display("FAIL clr_sum got=%0d exp=-29", sum_ext[0]); end
    tick;
    // Clear while holding a frame: the frame is dropped.
    out_ready[0] = 1'b0;
    for (int i = 0; i < 4; i++) push(0, 50, ok);
    vectors++; if (out_valid[0] !== 1'b1) begin miscompares++; $display("FAIL clr_hold_valid got=%b exp=1", out_valid[0]); end
    clear[0] = 1'b1;
    tick;
    clear[0] = 1'b0;
    vectors++; if (out_valid[0] !== 1'b0) begin miscompares++; $display("FAIL clr_hold_drop got=%b exp=0", out_valid[0]); end
    vectors++; if (in_ready[0] !== 1'b1) begin miscompares++; $display("FAIL clr_hold_ready got=%b exp=1", in_ready[0]); end
    out_ready[0] = 1'b1;
    for (int i = 1; i <= 4; i++) push(0, i, ok);
    vectors++; if (sum_ext[0] !== 10) begin miscompares++; $display("FAIL clr_after_sum got=%0d exp=10", sum_ext[0]); end
    tick;
  endtask

  task automatic test_async_reset;
    bit ok;
    // Mid-frame: out_sum still shows the previous frame (10) until reset.
    push(0, 5, ok);
    push(0, 5, ok);
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (sum_ext[0] !== 0) begin miscompares++; $display("FAIL arst_mid_sum got=%0d exp=0", sum_ext[0]); end
    vectors++; if (out_valid[0] !== 1'b0) begin miscompares++; $display("FAIL arst_mid_valid got=%b exp=0", out_valid[0]); end
    rst_n = 1'b1;
    tick;
    // In HOLD
    out_ready[0] = 1'b0;
    for (int i = 0; i < 4; i++) push(0, 127, ok);
    vectors++; if (out_valid[0] !== 1'b1) begin miscompares++; $display("FAIL arst_hold_pre got=%b exp=1", out_valid[0]); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (out_valid[0] !== 1'b0) begin miscompares++; $display("FAIL arst_hold_valid got=%b exp=0", out_valid[0]); end
    vectors++; if (sum_ext[0] !== 0) begin miscompares++; $display("FAIL arst_hold_sum got=%0d exp=0", sum_ext[0]); end
    vectors++; if (out_ovf[0] !== 1'b0) begin miscompares++; $display("FAIL arst_hold_ovf got=%b exp=0", out_ovf[0]); end
    rst_n = 1'b1;
    tick;
    vectors++; if (in_ready[0] !== 1'b1) begin miscompares++; $display("FAIL arst_release_ready got=%b exp=1", in_ready[0]); end
    out_ready[0] = 1'b1;
    for (int i = 0; i < 4; i++) push(0, 64, ok);
    vectors++; if (sum_ext[0] !== 256) begin miscompares++; $display("FAIL arst_next_sum got=%0d exp=256", sum_ext[0]); end
    vectors++; if (out_ovf[0] !== 1'b0) begin miscompares++; $display("FAIL arst_next_ovf got=%b exp=0", out_ovf[0]); end
    tick;
  endtask

  task automatic test_random(input int d, input int frames);
    int q[$];
    int exp, p, waits;
    bit eo, ok;
    for (int f = 0; f < frames; f++) begin
      q.delete();
      out_ready[d] = 1'b0;
      for (int i = 0; i < frame_len_of(d); i++) begin
        repeat ($urandom_range(0, 2)) begin
          in_prod[d] = 8'(rnd_prod());  // not valid, must be ignored
          tick;
        end
        p = rnd_prod();
        q.push_back(p);
        push(d, p, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rnd_accept d=%0d f=%0d got=timeout exp=accept", d, f); end
      end
      model(d, q, exp, eo);
      waits = int'($urandom_range(0, 3));
      for (int w = 0; w < waits; w++) begin
        vectors++; if (sum_ext[d] !== exp) begin miscompares++; $display("FAIL rnd_hold_sum d=%0d f=%0d got=%0d exp=%0d", d, f, sum_ext[d], exp); end
        tick;
      end
      out_ready[d] = 1'b1;
      vectors++; if (out_valid[d] !== 1'b1) begin miscompares++; $display("FAIL rnd_valid d=%0d f=%0d got=%b exp=1", d, f, out_valid[d]); end
      vectors++; if (sum_ext[d] !== exp) begin miscompares++; $display("FAIL rnd_sum d=%0d f=%0d got=%0d exp=%0d", d, f, sum_ext[d], exp); end
      vectors++; if (out_ovf[d] !== eo) begin miscompares++; $display("FAIL rnd_ovf d=%0d f=%0d got=%b exp=%b", d, f, out_ovf[d], eo); end
      tick;
      out_ready[d] = 1'b0;
      vectors++; if (out_valid[d] !== 1'b0) begin miscompares++; $display("FAIL rnd_done d=%0d f=%0d got=%b exp=0", d, f, out_valid[d]); end
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      in_prod[d]   = '0;
      clear[d]     = 1'b0;
      out_ready[d] = 1'b0;
    end
    test_reset;
    test_basic;
    test_backpressure;
    test_ovf_small;
    test_clear;
    test_async_reset;
    test_random(0, 8);
    test_random(1, 8);
    test_random(2, 16);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter: ACC_W, default 12, accumulator and output sum width in bits (allowed range 8..32).
REQ-002 Parameter: FRAME_LEN, default 4, number of products summed per output frame (allowed range 1..255).
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: in_valid  input  1  in_prod holds a valid product this cycle.
REQ-006 Port: in_ready  output  1  block accepts a product this cycle.
REQ-007 Port: in_prod  input  8  signed product from the upstream 4x4 Booth multiplier stage.
REQ-008 Port: clear  input  1  synchronous frame abort.
REQ-009 Port: out_valid  output  1  out_sum and out_ovf hold a completed frame.
REQ-010 Port: out_ready  input  1  downstream accepts the frame this cycle.
REQ-011 Port: out_sum  output  ACC_W  signed frame sum.
REQ-012 Port: out_ovf  output  1  signed overflow occurred at least once during this frame.

Function
REQ-013 A product is accepted when in_valid and in_ready are both 1 on a rising clk edge; a frame is delivered when out_valid and out_ready are both 1.
REQ-014 The block has two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-015 In ACCUM, each accepted product is sign-extended to ACC_W bits, added to acc, and cnt is incremented.
REQ-016 The product accepted with cnt==FRAME_LEN-1 moves the block to HOLD on the same edge, and out_sum is loaded with the final sum; out_valid goes to 1 in the cycle after the last accept.
REQ-017 In HOLD, out_sum and out_ovf stay stable until delivery; on delivery the block moves to ACCUM with acc=0, cnt=0 and ovf=0.
REQ-018 A new product cannot be accepted in the delivery cycle (in_ready=0 in HOLD), so back-to-back throughput is FRAME_LEN+1 cycles per frame.
REQ-019 A signed overflow is an add whose true result lies outside [-2^(ACC_W-1), 2^(ACC_W-1)-1]; it sets a sticky ovf flag for the current frame.
REQ-020 clear=1 forces ACCUM, acc=0, cnt=0 and ovf=0, and it overrides any accept or delivery in the same cycle.
REQ-021 A frame held in HOLD when clear=1 is discarded.
REQ-022 When FRAME_LEN=1, every accepted product goes directly to HOLD.
REQ-023 in_prod is ignored when not accepted; out_sum is only meaningful while out_valid=1.

Reset
REQ-024 rst_n=0 immediately sets state=ACCUM, acc=0, cnt=0, ovf=0, out_sum=0, out_valid=0 and out_ovf=0, and in_ready reads 1 once reset is released.
REQ-025 An assertion of reset mid-frame or in HOLD discards all partial and held data, and no frame is emitted for it.

Configuration
REQ-026 With macro ACC_SAT_EN defined, an overflowing add clamps acc to 2^(ACC_W-1)-1 (positive overflow) or -2^(ACC_W-1) (negative overflow).
REQ-027 Without ACC_SAT_EN, acc wraps modulo 2^ACC_W.
REQ-028 Overflow detection and out_ovf behave identically in both builds.

Structure
REQ-029 A shared package holds the state encoding (ACCUM, HOLD), the product width constant 8, and the saturation limit constants derived from ACC_W.
REQ-030 One sub-module, sat_adder (ACC_W-bit signed add with overflow flag and the ACC_SAT_EN clamp), is instantiated once; the FSM and counter stay in the top level.

Verification
REQ-031 Defaults, in_prod=-21,-49,49,6 with in_valid held at 1 and out_ready=1 -> out_valid=1 one cycle after the 4th accept, out_sum=-15, out_ovf=0, then a single-cycle pulse.
REQ-032 Backpressure: complete a frame with out_ready=0 for 5 cycles -> in_ready=0 and out_sum stable throughout; the frame is delivered on the first out_ready=1 cycle, and a product offered meanwhile is accepted only after return to ACCUM.
REQ-033 ACC_W=8, FRAME_LEN=2, products 64,64 -> with ACC_SAT_EN out_sum=127, out_ovf=1; without it out_sum=-128, out_ovf=1; products -64,-64 -> out_sum=-128, out_ovf=0 in both builds.
REQ-034 clear asserted after 2 of 4 accepts, then -40,-10,6,15 -> out_sum=-29 (earlier products excluded); clear asserted together with in_valid -> that product is dropped.
REQ-035 rst_n pulsed low asynchronously mid-frame and in HOLD -> outputs zero at once with no clk edge needed, and the next full frame of 4x(-8*-8=64) gives out_sum=256, out_ovf=0.
